// File: rtl/cgia_pkg.sv
// Shared definitions for the CGIA fetch path: default widths, the
// scheduler state encoding and the fetch command record that the
// scheduler issues and the fetcher consumes.
package cgia_pkg;

    localparam int CGIA_ADDR_W = 23;
    localparam int CGIA_CNT_W  = 8;
    localparam int CGIA_LINE_W = 10;

    // Scheduler states. Code 2'd3 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;

    // One fetch command: start word address, word count, target line buffer.
    typedef struct packed {
        logic [CGIA_ADDR_W-1:0] adr;
        logic [CGIA_CNT_W-1:0]  count;
        logic                   buf_sel;
    } fetch_cmd_t;

    // Start address of the following line. Wraps modulo 2^CGIA_ADDR_W.
    function automatic logic [CGIA_ADDR_W-1:0] next_line_adr(
        input logic [CGIA_ADDR_W-1:0] adr,
        input logic [CGIA_ADDR_W-1:0] pitch
    );
        return adr + pitch;
    endfunction

endpackage

// File: rtl/cgia_line_scheduler.sv
// Per-scanline DMA sequencer. A frame-start pulse loads the framebuffer
// base address. Each line-start pulse swaps the ping-pong line buffers
// and commands the fetcher to fill the buffer that is no longer shown.
// A line-start that arrives while a fetch is still outstanding raises a
// sticky underrun flag. The finished line is then shown at the following
// line-start.
module cgia_line_scheduler
    import cgia_pkg::*;
#(
    parameter int ADDR_W = CGIA_ADDR_W,
    parameter int CNT_W  = CGIA_CNT_W,
    parameter int LINE_W = CGIA_LINE_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              vsync_i,
    input  logic              hsync_i,
    input  logic [ADDR_W-1:0] fb_base_i,
    input  logic [ADDR_W-1:0] pitch_i,
    input  logic [CNT_W-1:0]  words_i,
    input  logic [LINE_W-1:0] lines_i,
    output logic              go_o,
    output logic [ADDR_W-1:0] start_adr_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              buf_sel_o,
    input  logic              done_i,
    output logic              disp_buf_o,
    output logic              underrun_o,
    input  logic              clr_underrun_i
);

    logic [1:0]        state_r,    state_s;
    logic [ADDR_W-1:0] line_adr_r, line_adr_s;
    logic [LINE_W-1:0] line_cnt_r, line_cnt_s;
    logic              fill_buf_r, fill_buf_s;
    logic              ready_r,    ready_s;
    logic              vs_pend_r,  vs_pend_s;
    logic              disp_buf_r, disp_buf_s;
    logic              underrun_r, underrun_s;
    logic              go_r,       go_s;
    fetch_cmd_t        cmd_r,      cmd_s;

    logic              vs_ev_s;
    logic              hs_ev_s;
    logic              frame_s;
    logic              issue_s;
    logic              ur_set_s;

    // Qualified sync events; a frame start masks a same-cycle line start.
    always_comb begin
        vs_ev_s  = enable_i & vsync_i;
        hs_ev_s  = enable_i & hsync_i & ~vsync_i;
        ur_set_s = hs_ev_s & (state_r != ST_IDLE);
    end

    // Next-state logic for the sequencer, line datapath and registered outputs.
    always_comb begin
        state_s    = state_r;
        line_adr_s = line_adr_r;
        line_cnt_s = line_cnt_r;
        fill_buf_s = fill_buf_r;
        ready_s    = ready_r;
        vs_pend_s  = vs_pend_r;
        disp_buf_s = disp_buf_r;
        cmd_s      = cmd_r;
        go_s       = 1'b0;
        frame_s    = 1'b0;
        issue_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (vs_ev_s) begin
                    frame_s = 1'b1;
                end else if (hs_ev_s && ready_r) begin
                    disp_buf_s = fill_buf_r;
                    fill_buf_s = ~fill_buf_r;
                    ready_s    = 1'b0;
                    issue_s    = (line_cnt_r < lines_i);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_FETCH;
                if (vs_ev_s) begin
                    vs_pend_s = 1'b1;
                end else begin
                    vs_pend_s = vs_pend_r;
                end
            end
            ST_FETCH: begin
                if (done_i) begin
                    state_s = ST_IDLE;
                    // A frame start seen during the fetch discards this line.
                    if ((enable_i && vs_pend_r) || vs_ev_s) begin
                        frame_s = 1'b1;
                    end else begin
                        line_adr_s = next_line_adr(line_adr_r, pitch_i);
                        line_cnt_s = line_cnt_r + LINE_W'(1);
                        ready_s    = 1'b1;
                    end
                end else if (vs_ev_s) begin
                    vs_pend_s = 1'b1;
                end else begin
                    vs_pend_s = vs_pend_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (frame_s) begin
            line_adr_s = fb_base_i;
            line_cnt_s = {LINE_W{1'b0}};
            fill_buf_s = 1'b0;
            ready_s    = 1'b0;
            vs_pend_s  = 1'b0;
            issue_s    = (lines_i != {LINE_W{1'b0}});
        end else begin
            line_adr_s = line_adr_s;
        end

        if (!enable_i) begin
            vs_pend_s = 1'b0;
        end else begin
            vs_pend_s = vs_pend_s;
        end

        if (issue_s) begin
            state_s = ST_ISSUE;
            go_s    = 1'b1;
            cmd_s   = '{adr: line_adr_s, count: words_i, buf_sel: fill_buf_s};
        end else begin
            go_s = 1'b0;
        end

        // A new underrun takes precedence over a same-cycle clear.
        if (ur_set_s) begin
            underrun_s = 1'b1;
        end else if (clr_underrun_i) begin
            underrun_s = 1'b0;
        end else begin
            underrun_s = underrun_r;
        end
    end

    // State and output registers; an async reset abandons any fetch in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r    <= ST_IDLE;
            line_adr_r <= {ADDR_W{1'b0}};
            line_cnt_r <= {LINE_W{1'b0}};
            fill_buf_r <= 1'b0;
            ready_r    <= 1'b0;
            vs_pend_r  <= 1'b0;
            disp_buf_r <= 1'b1;
            underrun_r <= 1'b0;
            go_r       <= 1'b0;
            cmd_r      <= '{adr: {ADDR_W{1'b0}}, count: {CNT_W{1'b0}}, buf_sel: 1'b0};
        end else begin
            state_r    <= state_s;
            line_adr_r <= line_adr_s;
            line_cnt_r <= line_cnt_s;
            fill_buf_r <= fill_buf_s;
            ready_r    <= ready_s;
            vs_pend_r  <= vs_pend_s;
            disp_buf_r <= disp_buf_s;
            underrun_r <= underrun_s;
            go_r       <= go_s;
            cmd_r      <= cmd_s;
        end
    end

    assign go_o        = go_r;
    assign start_adr_o = cmd_r.adr;
    assign count_o     = cmd_r.count;
    assign buf_sel_o   = cmd_r.buf_sel;
    assign disp_buf_o  = disp_buf_r;
    assign underrun_o  = underrun_r;

endmodule

// File: doc/cgia_line_scheduler.md
Name: cgia_line_scheduler

Overview:
- Per-scanline DMA sequencer for the CGIA fetcher.
- On frame start it loads the framebuffer base address. On each line start it commands the fetcher to read one line of 16-bit words into one of two line buffers.
- It ping-pongs those buffers and tells the video shifter which buffer to display.
- It sits between the CRTC timing generator (hsync/vsync pulses) and the fetcher's command/status port.

Parameters:
- ADDR_W, 23, word-address width (16-bit words).
- CNT_W, 8, width of the words-per-line count.
- LINE_W, 10, width of the line counter.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  fetching enabled.
- vsync_i  in  1  one-cycle frame-start pulse.
- hsync_i  in  1  one-cycle line-start pulse.
- fb_base_i  in  ADDR_W  framebuffer base word address.
- pitch_i  in  ADDR_W  words between successive line starts.
- words_i  in  CNT_W  words to fetch per line.
- lines_i  in  LINE_W  lines per frame.
- go_o  out  1  one-cycle fetch command strobe to fetcher.
- start_adr_o  out  ADDR_W  fetch start address.
- count_o  out  CNT_W  fetch word count.
- buf_sel_o  out  1  line buffer the fetcher fills.
- done_i  in  1  one-cycle pulse: fetcher finished the last word.
- disp_buf_o  out  1  line buffer the shifter reads.
- underrun_o  out  1  sticky underrun flag.
- clr_underrun_i  in  1  clears underrun_o.

Behaviour:
- Reset (reset_i low, async) sets: go_o=0, start_adr_o=0, count_o=0, buf_sel_o=0, disp_buf_o=1, underrun_o=0.
- Reset also clears internal state: FSM=IDLE, line_adr=0, line_cnt=0, fill_buf=0, ready=0, vs_pend=0.
- Reset mid-fetch abandons the fetch. The fetcher resets on the same signal.
- FSM has three states: IDLE, ISSUE, FETCH.
- ISSUE (one cycle):
  - go_o=1, start_adr_o=line_adr, count_o=words_i, buf_sel_o=fill_buf.
  - Next state FETCH.
  - start_adr_o, count_o and buf_sel_o hold until the next ISSUE.
- Command latency: go_o rises in the cycle following the edge that samples the triggering hsync_i/vsync_i.
- FETCH waits for done_i. On done_i:
  - line_adr += pitch_i, modulo 2^ADDR_W (wraps silently).
  - line_cnt += 1.
  - ready=1.
  - Go to IDLE.
- vsync_i with enable_i=1:
  - Sampled in IDLE: line_adr=fb_base_i, line_cnt=0, fill_buf=0, ready=0. Go to ISSUE if lines_i!=0, else stay IDLE.
  - Sampled in ISSUE/FETCH: set vs_pend. On done_i, discard the result (ready stays 0) and perform the IDLE vsync action.
- hsync_i in IDLE with ready=1:
  - disp_buf_o=fill_buf, fill_buf=~fill_buf, ready=0.
  - If line_cnt<lines_i, go to ISSUE; otherwise swap only, no fetch.
- hsync_i in IDLE with ready=0: ignored (nothing fetched this frame yet, or end of frame).
- hsync_i in ISSUE/FETCH (line not ready): underrun_o=1, disp_buf_o unchanged, fetch continues. The completed line is swapped at the next hsync.
- vsync_i and hsync_i in the same cycle: vsync wins, hsync is ignored.
- set and clr_underrun_i in the same cycle: set wins.
- enable_i=0:
  - hsync_i and vsync_i are ignored; no new ISSUE.
  - An in-flight fetch completes normally.
  - vs_pend is cleared.
- Widths: line_cnt compares unsigned against lines_i. count_o is words_i unmodified; 0 is passed through and is the fetcher's concern.

Decomposition:
- Shared package cgia_pkg holds:
  - state encoding (IDLE, ISSUE, FETCH);
  - default ADDR_W/CNT_W/LINE_W;
  - fetcher command record (adr, count, buf_sel), reused by fetcher and scheduler.
- No sub-module needed. The address/line-counter datapath stays inline.

Test Plan:
- Reset: assert reset_i low mid-fetch -> all outputs at reset values immediately; go_o never pulses until the next vsync after release.
- Frame start: fb_base=0x1000, pitch=0x50, words=40, lines=3, vsync -> one go_o with start_adr_o=0x1000, count_o=40, buf_sel_o=0.
- Ping-pong: done, hsync -> disp_buf_o=0, go_o with start_adr_o=0x1050, buf_sel_o=1. Repeat -> 0x10A0, buf_sel_o=0. Third hsync -> swap only, no go_o.
- Underrun: hsync while FETCH -> underrun_o=1, disp_buf_o unchanged. Then done, hsync -> swap. clr_underrun_i with a simultaneous new underrun -> stays 1.
- vsync mid-fetch: vsync during FETCH -> no go_o until done_i. Then go_o with start_adr_o=fb_base_i and buf_sel_o=0. Same-cycle hsync+vsync -> vsync behaviour only.
- Wrap/disable: fb_base=2^23-0x10, pitch=0x20 -> second start_adr_o=0x10. enable_i=0 -> hsync produces no go_o; in-flight done still sets ready.
